// File: rtl/importance_topk.sv
// Streaming top-K selector: keeps the K largest importance scores of a run,
// sorted descending, using one-cycle insertion into a shift table.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start, table and flags at reset
// COLLECT | accepting NTOK scores, inserting each on accept
// DONE    | run finished, table final, out_valid held high
module importance_topk #(
  parameter int width = 8,
  parameter int NTOK  = 16,
  parameter int K     = 4,
  localparam int IDXW = $clog2(NTOK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*width-1:0]    importance,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic [K*2*width-1:0]  top_val,
  output logic [K*IDXW-1:0]     top_idx
);

  localparam int VW = 2 * width;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [VW-1:0]     val_q [K];
  logic [IDXW-1:0]   idx_q [K];
  logic [K-1:0]      occ_q;
  logic [IDXW-1:0]   cnt_q;
  logic [K-1:0]      ge, ins, sh;
  logic              accept, last, enter;

  assign accept = in_valid && in_ready;
  assign last   = (cnt_q == IDXW'(NTOK - 1));
  assign enter  = start && (state != S_COLLECT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (accept && last) state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_COLLECT);
    busy     = (state == S_COLLECT);
  end

  // The table is always sorted, so ge is a prefix of ones; the new score lands
  // at the first slot that is not >= it, and everything below shifts down.
  always_comb begin
    for (int i = 0; i < K; i++) ge[i] = occ_q[i] && (val_q[i] >= importance);
    ins    = '0;
    sh     = '0;
    ins[0] = !ge[0];
    for (int i = 1; i < K; i++) begin
      ins[i] = !ge[i] && ge[i-1];
      sh[i]  = !ge[i] && !ge[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || enter) begin
      for (int i = 0; i < K; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
      occ_q     <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= accept && last;
      if (accept && last) out_valid <= 1'b1;
      if (accept) begin
        cnt_q <= cnt_q + IDXW'(1);
        for (int i = 0; i < K; i++) begin
          if (ins[i]) begin
            val_q[i] <= importance;
            idx_q[i] <= cnt_q;
            occ_q[i] <= 1'b1;
          end
        end
        for (int i = 1; i < K; i++) begin
          if (sh[i]) begin
            val_q[i] <= val_q[i-1];
            idx_q[i] <= idx_q[i-1];
            occ_q[i] <= occ_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      top_val[i*VW +: VW]     = val_q[i];
      top_idx[i*IDXW +: IDXW] = idx_q[i];
    end
  end

endmodule

// File: tb/tb_importance_topk.sv
// Scoreboard bench for importance_topk: a K=4 and a K=1 build share stimulus;
// expected tables are computed by selection from the driven scores.
module tb_importance_topk;

  localparam int W = 8, NT = 16, KK = 4, IW = 4, VW = 16;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [VW-1:0] importance;
  logic in_ready4, busy4, done4, ov4;
  logic [KK*VW-1:0] tv4;
  logic [KK*IW-1:0] ti4;
  logic in_ready1, busy1, done1, ov1;
  logic [VW-1:0] tv1;
  logic [IW-1:0] ti1;

  always #5 clk = ~clk;

  importance_topk #(.width(W), .NTOK(NT), .K(KK)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .importance(importance), .busy(busy4), .done(done4), .out_valid(ov4),
    .top_val(tv4), .top_idx(ti4));

  importance_topk #(.width(W), .NTOK(NT), .K(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .importance(importance), .busy(busy1), .done(done1), .out_valid(ov1),
    .top_val(tv1), .top_idx(ti1));

  typedef struct {
    logic [KK*VW-1:0] v;
    logic [KK*IW-1:0] i;
    logic [VW-1:0]    v1;
    logic [IW-1:0]    i1;
  } exp_t;

  exp_t q[$];
  logic [VW-1:0] s [NT];
  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Selection model: repeatedly take the largest unused score, earliest index on ties.
  function automatic exp_t model();
    exp_t e;
    bit used [NT];
    int best;
    for (int t = 0; t < NT; t++) used[t] = 1'b0;
    e.v = '0;
    e.i = '0;
    for (int j = 0; j < KK; j++) begin
      best = -1;
      for (int t = 0; t < NT; t++)
        if (!used[t] && (best < 0 || s[t] > s[best])) best = t;
      used[best] = 1'b1;
      e.v[j*VW +: VW] = s[best];
      e.i[j*IW +: IW] = IW'(best);
      if (j == 0) begin
        e.v1 = s[best];
        e.i1 = IW'(best);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done4 || done1) begin
      if (q.size() == 0) begin
        check("spurious_done", {62'd0, done4, done1}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_k1", done1, 1'b1);
        check("done_k4", done4, 1'b1);
        check("ov_at_done", ov4, 1'b1);
        check("top_val", tv4, e.v);
        check("top_idx", ti4, e.i);
        check("k1_val", tv1, e.v1);
        check("k1_idx", ti1, e.i1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit gaps, input bit mid_start);
    q.push_back(model());
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", in_ready4, 1'b1);
    check("busy_after_start", busy4, 1'b1);
    check("ov_cleared", ov4, 1'b0);
    check("val_cleared", tv4, '0);
    check("idx_cleared", ti4, '0);
    check("k1_cleared", tv1, '0);
    for (int t = 0; t < NT; t++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            importance = 16'($urandom);
            tick();
          end
        end
      end
      in_valid   = 1'b1;
      importance = s[t];
      if (mid_start && t == 5) start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (t == NT - 2) check("no_early_done", done4, 1'b0);
    end
    check("ov_after_last", ov4, 1'b1);
    check("state_done", busy4, 1'b0);
    tick();
    check("done_pulse_end", done4, 1'b0);
    check("ov_held", ov4, 1'b1);
    check("ready_in_done", in_ready4, 1'b0);
    tick();
    check("sb_drained", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; importance = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy4, 1'b0);
    check("rst_ready", in_ready4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_ov", ov4, 1'b0);
    check("rst_val", tv4, '0);
    check("rst_idx", ti4, '0);

    // in_valid while IDLE is ignored
    in_valid = 1'b1;
    importance = 16'h00AA;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_ready", in_ready4, 1'b0);
      check("idle_val", tv4, '0);
    end
    in_valid = 1'b0;

    for (int t = 0; t < NT; t++) s[t] = 16'(t + 1);
    run(1'b0, 1'b0);
    check("asc_val", tv4, {16'd13, 16'd14, 16'd15, 16'd16});
    check("asc_idx", ti4, {4'd12, 4'd13, 4'd14, 4'd15});

    for (int t = 0; t < NT; t++) s[t] = 16'd5;
    run(1'b0, 1'b1);
    check("eq_idx", ti4, {4'd3, 4'd2, 4'd1, 4'd0});

    for (int t = 0; t < NT; t++) s[t] = 16'd1;
    s[0] = 16'h0000; s[3] = 16'hFFFF; s[9] = 16'h8000;
    run(1'b1, 1'b0);
    check("ext_val", tv4, {16'd1, 16'd1, 16'h8000, 16'hFFFF});
    check("ext_idx", ti4, {4'd2, 4'd1, 4'd9, 4'd3});

    // mid-run reset: seven transfers, then abandon
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      in_valid = 1'b1;
      importance = 16'(100 + t);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr_busy", busy4, 1'b0);
    check("mr_ov", ov4, 1'b0);
    check("mr_val", tv4, '0);
    for (int c = 0; c < 20; c++) tick();
    for (int t = 0; t < NT; t++) s[t] = 16'(NT - t);
    run(1'b0, 1'b0);
    check("desc_idx", ti4, {4'd3, 4'd2, 4'd1, 4'd0});

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy4, 1'b0);
    check("rst_start_ov", ov4, 1'b0);
    tick();
    check("rst_start_idle", in_ready4, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < NT; t++)
        s[t] = (r % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 6));
      run(r[0], r == 3);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
